// File: rtl/serial_link_pkg.sv
// Shared line definitions for the serial word link: FSM encodings and line levels,
// used by both the transmitter and the matching capture-flop receiver.
package serial_link_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } link_state_t;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

   // Frame length in bit times: start + data + optional parity + stop.
   function automatic int frame_bits(input int width, input bit parity_en);
      return width + 2 + (parity_en ? 1 : 0);
   endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// WIDTH-bit load / shift-right register; bit 0 is the next data bit for the line.
module serial_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             lsb
);

   logic [WIDTH-1:0] shreg_reg;
   logic [WIDTH-1:0] shifted;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == WIDTH - 1) begin : g_top
         assign shifted[gi] = 1'b0;
      end else begin : g_low
         assign shifted[gi] = shreg_reg[gi+1];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shreg_reg <= '0;
      end else if (load) begin
         shreg_reg <= din;
      end else if (shift) begin
         shreg_reg <= shifted;
      end
   end

   assign lsb = shreg_reg[0];

endmodule

// File: rtl/serial_word_tx.sv
// Word-to-serial transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Line outputs are registered, so the start bit appears one clock after the accept edge.
module serial_word_tx
   import serial_link_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit PARITY_EN = 1'b0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             sdata,
   output logic             sframe,
   output logic             busy
);

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

   link_state_t      state_reg;
   link_state_t      state_next;
   logic [CNT_W-1:0] count_reg;
   logic             parity_reg;
   logic             sdata_reg;
   logic             sframe_reg;
   logic             busy_reg;
   logic             sdata_next;
   logic             sframe_next;
   logic             accept;
   logic             shift;
   logic             shift_lsb;

   // Ready in STOP as well as IDLE lets back-to-back frames run without an idle gap.
   assign tx_ready = reset_n & ((state_reg == ST_IDLE) | (state_reg == ST_STOP));
   assign accept   = tx_valid & tx_ready;

   serial_shift_reg #(
      .WIDTH(WIDTH)
   ) u_shreg (
      .clock  (clock),
      .reset_n(reset_n),
      .load   (accept),
      .shift  (shift),
      .din    (tx_data),
      .lsb    (shift_lsb)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = ST_IDLE;
      case (state_reg)
         ST_IDLE:   state_next = accept ? ST_START : ST_IDLE;
         ST_START:  state_next = ST_DATA;
         ST_DATA: begin
            if (count_reg == LAST_BIT) begin
               state_next = PARITY_EN ? ST_PARITY : ST_STOP;
            end else begin
               state_next = ST_DATA;
            end
         end
         ST_PARITY: state_next = ST_STOP;
         ST_STOP:   state_next = accept ? ST_START : ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      sdata_next  = IDLE_LEVEL;
      sframe_next = 1'b1;
      shift       = 1'b0;
      case (state_reg)
         ST_IDLE:   sframe_next = 1'b0;
         ST_START:  sdata_next  = START_LEVEL;
         ST_DATA: begin
            sdata_next = shift_lsb;
            shift      = 1'b1;
         end
         ST_PARITY: sdata_next  = parity_reg;
         ST_STOP:   sdata_next  = STOP_LEVEL;
         default:   sframe_next = 1'b0;
      endcase
   end

   // busy follows the next state so it rises on the accept edge and drops on leaving STOP.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sdata_reg  <= IDLE_LEVEL;
         sframe_reg <= 1'b0;
         busy_reg   <= 1'b0;
         count_reg  <= '0;
         parity_reg <= 1'b0;
      end else begin
         sdata_reg  <= sdata_next;
         sframe_reg <= sframe_next;
         busy_reg   <= (state_next != ST_IDLE);
         if (accept) begin
            parity_reg <= ^tx_data;
         end
         if (state_reg == ST_START) begin
            count_reg <= '0;
         end else if ((state_reg == ST_DATA) && (count_reg != LAST_BIT)) begin
            count_reg <= count_reg + 1'b1;
         end
      end
   end

   assign sdata  = sdata_reg;
   assign sframe = sframe_reg;
   assign busy   = busy_reg;

endmodule
